jvm_uop_sequencer: RTL

Parametrised micro-op sequencer for the bytecode front end. It accepts one instruction at a time (opcode plus one operand byte) and looks up its micro-op list in a table sub-module. It issues 1..MAX_UOPS micro-ops per opcode over a valid/ready handshake, stalling on back-pressure. It also drives a free-running memory address that advances on each memory-flagged micro-op. It sits between the instruction fetch buffer and the execution unit.

---
 rtl/jvm_pkg.sv | 45 ++++
 rtl/jvm_uop_sequencer_uop_rom.sv | 40 ++++
 rtl/jvm_uop_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/jvm_pkg.sv
// Shared definitions for the bytecode micro-op sequencer: opcodes, table
// entry layout, sequencer states and the default micro-op word.
package jvm_pkg;

    localparam int unsigned ENTRY_UOP_W = 32;

    localparam logic [7:0] IADD     = 8'h60;
    localparam logic [7:0] I2B      = 8'h91;
    localparam logic [7:0] DLOAD    = 8'h18;
    localparam logic [7:0] ICONST_0 = 8'h03;
    localparam logic [7:0] LCMP     = 8'h94;

    localparam logic [ENTRY_UOP_W-1:0] UOP_NOP_BASE = 32'h920104E0;

    typedef struct packed {
        logic                   vld;
        logic                   last;
        logic                   mem;
        logic                   imm;
        logic [ENTRY_UOP_W-1:0] uop;
    } uop_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        DONE
    } seq_state_t;

    localparam uop_entry_t ENTRY_NONE = '0;

    function automatic uop_entry_t make_entry(input logic                   is_last,
                                              input logic                   is_mem,
                                              input logic                   is_imm,
                                              input logic [ENTRY_UOP_W-1:0] word);
        uop_entry_t e;
        e.vld  = 1'b1;
        e.last = is_last;
        e.mem  = is_mem;
        e.imm  = is_imm;
        e.uop  = word;
        return e;
    endfunction

endpackage

// File: rtl/jvm_uop_sequencer_uop_rom.sv
// Micro-op table: registered read addressed by {opcode, index}; opcodes
// without an entry return vld=0.
module uop_rom
    import jvm_pkg::*;
#(
    parameter int unsigned OPCODE_W = 8,
    parameter int unsigned IDX_W    = 2
) (
    input  logic                      clk,
    input  logic [OPCODE_W+IDX_W-1:0] addr,
    output uop_entry_t                entry
);

    logic [OPCODE_W-1:0] op;
    logic [IDX_W-1:0]    idx;
    uop_entry_t          lookup;

    assign {op, idx} = addr;

    always_comb begin
        lookup = ENTRY_NONE;
        if (op == OPCODE_W'(IADD)) begin
            if (idx == '0)
                lookup = make_entry(1'b0, 1'b0, 1'b0, UOP_NOP_BASE);
            else if (idx == IDX_W'(1))
                lookup = make_entry(1'b1, 1'b0, 1'b0, 32'h920104E1);
        end else if (op == OPCODE_W'(I2B)) begin
            if (idx == '0)
                lookup = make_entry(1'b1, 1'b1, 1'b0, UOP_NOP_BASE);
        end else if (op == OPCODE_W'(DLOAD)) begin
            if (idx == '0)
                lookup = make_entry(1'b1, 1'b0, 1'b1, 32'h92010400);
        end
    end

    always_ff @(posedge clk) begin
        entry <= lookup;
    end

endmodule

// File: rtl/jvm_uop_sequencer.sv
// Bytecode micro-op sequencer: latches one instruction, walks its table
// entries and issues each micro-op over a valid/ready handshake.
module jvm_uop_sequencer
    import jvm_pkg::*;
#(
    parameter int unsigned OPCODE_W = 8,
    parameter int unsigned UOP_W    = 32,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned MAX_UOPS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2*OPCODE_W-1:0] instr_in,
    output logic                  ready,
    output logic [UOP_W-1:0]      uop_out,
    output logic                  uop_valid,
    input  logic                  uop_ready,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  done,
    output logic                  illegal
);

    localparam int unsigned IDX_W = $clog2(MAX_UOPS);

    seq_state_t          state, state_nx;
    logic [IDX_W-1:0]    index, index_nx;
    logic [OPCODE_W-1:0] opcode_q, operand_q;
    logic                illegal_q, illegal_nx;
    logic                mem_req_q, mem_req_nx;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                accept;
    uop_entry_t          entry;
    logic [UOP_W-1:0]    uop_word;

    uop_rom #(
        .OPCODE_W(OPCODE_W),
        .IDX_W   (IDX_W)
    ) u_rom (
        .clk  (clk),
        .addr ({opcode_q, index}),
        .entry(entry)
    );

    always_comb begin
        uop_word = UOP_W'(entry.uop);
        if (entry.imm)
            uop_word[OPCODE_W-1:0] = operand_q;
    end

    assign accept = (state == IDLE) && start;

    always_comb begin
        state_nx   = state;
        index_nx   = index;
        illegal_nx = illegal_q;
        mem_req_nx = 1'b0;
        ready      = 1'b0;
        uop_valid  = 1'b0;
        uop_out    = '0;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nx   = FETCH;
                    index_nx   = '0;
                    illegal_nx = 1'b0;
                end
            end
            FETCH: state_nx = ISSUE;
            ISSUE: begin
                // An empty slot ends the list; only an empty first slot is illegal.
                if (!entry.vld) begin
                    state_nx   = DONE;
                    illegal_nx = (index == '0);
                end else begin
                    uop_valid = 1'b1;
                    uop_out   = uop_word;
                    if (uop_ready) begin
                        mem_req_nx = entry.mem;
                        if (entry.last || index == IDX_W'(MAX_UOPS - 1)) begin
                            state_nx = DONE;
                        end else begin
                            index_nx = index + 1'b1;
                            state_nx = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                illegal  = illegal_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            index      <= '0;
            opcode_q   <= '0;
            operand_q  <= '0;
            illegal_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state     <= state_nx;
            index     <= index_nx;
            illegal_q <= illegal_nx;
            mem_req_q <= mem_req_nx;
            if (accept) begin
                opcode_q  <= instr_in[2*OPCODE_W-1:OPCODE_W];
                operand_q <= instr_in[OPCODE_W-1:0];
            end
            if (mem_req_nx)
                mem_addr_q <= mem_addr_q + 1'b1;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule
